riscie_datapath: RTL and testbench
==================================

Name: riscie_datapath

Overview:
- Single-bus 32-bit CPU datapath for the RISCie processor, driven cycle-by-cycle by an external control sequencer through individual register in/out strobes.
- Contains the PC, IR, MAR, MDR, Y, 64-bit Z (ZHI/ZLO), HI, LO and general registers R2/R4, one shared bus multiplexer, and a combinational ALU selected by CONTROL.
- Multiply results go from Z to LO and HI over the bus.

Parameters:
- WIDTH, 32, bus and register width; Z and the multiply product are 2*WIDTH.
- PC_INC, 1, amount added to PC when IncPC is asserted.

Ports:
- Clock  in  1  system clock; all registers update on the rising edge.
- Clear  in  1  asynchronous active-high reset of every register.
- MData_In  in  32  memory read data into MDR.
- CONTROL  in  5  ALU operation select.
- IncPC  in  1  ALU forced to bus+PC_INC, overriding CONTROL.
- Read  in  1  MDR input mux: 1 selects MData_In, 0 selects the bus.
- PC_Out, MDR_Out, ZLO_Out, R2_Out, R4_Out  in  1 each  bus drive enables.
- PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_IN, ZLO_In, R2_In, R4_In, HI_In, LO_In  in  1 each  register load enables.

Behaviour:
- Reset: Clear=1 asynchronously zeroes PC, IR, MAR, MDR, Y, ZHI, ZLO, HI, LO, R2, R4. It has priority over all loads, including mid-operation.
- Bus:
  - Combinational mux with fixed priority when several enables are high: PC_Out > MDR_Out > ZLO_Out > R2_Out > R4_Out.
  - No enable asserted gives bus = 0.
- Register loads:
  - X_In=1 at a rising edge loads the bus into X, except MDR, which loads MData_In when Read=1 and the bus otherwise.
  - Registers hold their value when their load enable is low.
- ALU operands: A = Y and B = bus. The 64-bit result is split into ZHI (bits 63:32) and ZLO (bits 31:0).
  - ZHI_IN loads ZHI and ZLO_In loads ZLO independently on the same edge.
- CONTROL encodings. Every operation except MUL zero-extends its result to 64 bits.
  - 00000 ADD: A+B.
  - 00001 SUB: A-B.
  - 00010 MUL: signed A*B, full 64-bit product.
  - 00011 AND.
  - 00100 OR.
  - 00101 SHR: logical, by B[4:0].
  - 00110 SHL: by B[4:0].
  - 00111 NEG: -B.
  - 01000 NOT: ~B.
  - Any other code: result 0.
- IncPC: when IncPC=1 the result is {32'b0, B+PC_INC} regardless of CONTROL. A+B and B+PC_INC wrap modulo 2^32 with no carry out.
- Simultaneous events:
  - A register may drive the bus and load in the same cycle; it captures its own old value.
  - Loading Y and using Y in the same cycle sees the old Y.
- Latency: ALU is purely combinational. Z is valid one edge after ZLO_In/ZHI_IN, and the value is available on the bus in the following cycle.
- Fetch sequence (PC=0):
  - T0: PC_Out, MAR_In, IncPC, ZLO_In gives MAR=0, ZLO=1.
  - T1: ZLO_Out, PC_In, Read, MDR_In gives PC=1, MDR=MData_In.
  - T2: MDR_Out, IR_In gives IR=MDR.
- MUL sequence:
  - T3: R2_Out, Y_In.
  - T4: R4_Out, CONTROL=00010, ZHI_IN, ZLO_In.
  - T5: ZLO_Out, LO_In.
  - HI is loaded from the bus with HI_In. ZHI reaches the bus only when DATAPATH_PROBE_EN is compiled in (ZHI_Out); without it HI captures the selected bus value, normally left unused.

Optional Feature:
- Macro DATAPATH_PROBE_EN.
- When defined, add these ports:
  - Input ZHI_Out: bus drive enable, lowest bus priority.
  - Outputs BusMux_Out[31:0], IR_Q, MAR_Q, HI_Q, LO_Q, PC_Q: continuous copies of the bus and registers.
- When undefined, none of these ports exist, ZHI is not bus-visible, and core behaviour is identical.

Decomposition:
- Shared package riscie_pkg: WIDTH, the CONTROL opcode constants (ALU_ADD … ALU_NOT), and the 5-bit alu_op_t typedef.
- Sub-module riscie_alu: purely combinational, inputs A, B, CONTROL, IncPC; output 64-bit result.
- Registers and the bus mux stay in the top level.

Test Plan:
- Reset: pulse Clear=1 mid-run with loads active -> every register reads 0 immediately, before the next Clock edge.
- Register load: MData_In=16, Read=1, MDR_In=1, then MDR_Out=1, R2_In=1 -> R2=16. Same with 32 -> R4=32.
- Fetch from PC=0, MData_In=0x70000000, T0–T2 -> MAR=0, PC=1, IR=0x70000000.
- MUL: R2=16, R4=32, T3–T5 -> ZLO=512, ZHI=0, LO=512.
- Signed MUL: Y=0xFFFFFFFD (-3), bus=5, CONTROL=00010 -> ZHI=0xFFFFFFFF, ZLO=0xFFFFFFF1.
- Priority and wrap: PC_Out and R2_Out both high -> bus=PC. IncPC with bus=0xFFFFFFFF -> ZLO=0, ZHI=0.

Source files
------------

// File: rtl/riscie_pkg.sv
// Shared widths and ALU opcode constants for the RISCie datapath.
package riscie_pkg;

  localparam int WIDTH = 32;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 5'b00000;
  localparam alu_op_t ALU_SUB = 5'b00001;
  localparam alu_op_t ALU_MUL = 5'b00010;
  localparam alu_op_t ALU_AND = 5'b00011;
  localparam alu_op_t ALU_OR  = 5'b00100;
  localparam alu_op_t ALU_SHR = 5'b00101;
  localparam alu_op_t ALU_SHL = 5'b00110;
  localparam alu_op_t ALU_NEG = 5'b00111;
  localparam alu_op_t ALU_NOT = 5'b01000;

  // Widen a single-word result into the upper-zero 64-bit Z format.
  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

endpackage

// File: rtl/riscie_alu.sv
// Combinational ALU: A = Y, B = bus; IncPC overrides CONTROL with B + PC_INC.
module riscie_alu
  import riscie_pkg::*;
#(
  parameter int PC_INC = 1
) (
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  alu_op_t            CONTROL,
  input  logic               IncPC,
  output logic [2*WIDTH-1:0] result
);

  logic signed [2*WIDTH-1:0] a_ext_s;
  logic signed [2*WIDTH-1:0] b_ext_s;
  logic signed [2*WIDTH-1:0] product_s;

  assign a_ext_s   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_ext_s   = {{WIDTH{B[WIDTH-1]}}, B};
  assign product_s = a_ext_s * b_ext_s;

  // Operation select; sums wrap within one word and never carry into ZHI.
  always_comb begin
    result = {(2*WIDTH){1'b0}};
    if (IncPC) begin
      result = zext(B + WIDTH'(PC_INC));
    end else begin
      case (CONTROL)
        ALU_ADD: result = zext(A + B);
        ALU_SUB: result = zext(A - B);
        ALU_MUL: result = product_s;
        ALU_AND: result = zext(A & B);
        ALU_OR:  result = zext(A | B);
        ALU_SHR: result = zext(A >> B[4:0]);
        ALU_SHL: result = zext(A << B[4:0]);
        ALU_NEG: result = zext(-B);
        ALU_NOT: result = zext(~B);
        default: result = {(2*WIDTH){1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/riscie_datapath.sv
// RISCie single-bus datapath. Define DATAPATH_PROBE_EN to add ZHI_Out and
// the bus/register observation ports.
module riscie_datapath
  import riscie_pkg::*;
#(
  parameter int PC_INC = 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] MData_In,
  input  logic [4:0]       CONTROL,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             PC_Out,
  input  logic             MDR_Out,
  input  logic             ZLO_Out,
  input  logic             R2_Out,
  input  logic             R4_Out,
  input  logic             PC_In,
  input  logic             MDR_In,
  input  logic             MAR_In,
  input  logic             IR_In,
  input  logic             Y_In,
  input  logic             ZHI_IN,
  input  logic             ZLO_In,
  input  logic             R2_In,
  input  logic             R4_In,
  input  logic             HI_In,
  input  logic             LO_In
`ifdef DATAPATH_PROBE_EN
  ,
  input  logic             ZHI_Out,
  output logic [WIDTH-1:0] BusMux_Out,
  output logic [WIDTH-1:0] IR_Q,
  output logic [WIDTH-1:0] MAR_Q,
  output logic [WIDTH-1:0] HI_Q,
  output logic [WIDTH-1:0] LO_Q,
  output logic [WIDTH-1:0] PC_Q
`endif
);

  logic [WIDTH-1:0]   pc_r, ir_r, mar_r, mdr_r, y_r;
  logic [WIDTH-1:0]   zhi_r, zlo_r, hi_r, lo_r, r2_r, r4_r;
  logic [WIDTH-1:0]   bus_s;
  logic [2*WIDTH-1:0] alu_result_s;

  // Shared bus with fixed source priority; an idle bus reads as zero.
  always_comb begin
    bus_s = {WIDTH{1'b0}};
    if (PC_Out) begin
      bus_s = pc_r;
    end else if (MDR_Out) begin
      bus_s = mdr_r;
    end else if (ZLO_Out) begin
      bus_s = zlo_r;
    end else if (R2_Out) begin
      bus_s = r2_r;
    end else if (R4_Out) begin
      bus_s = r4_r;
`ifdef DATAPATH_PROBE_EN
    end else if (ZHI_Out) begin
      bus_s = zhi_r;
`endif
    end else begin
      bus_s = {WIDTH{1'b0}};
    end
  end

  riscie_alu #(
    .PC_INC (PC_INC)
  ) u_alu (
    .A       (y_r),
    .B       (bus_s),
    .CONTROL (CONTROL),
    .IncPC   (IncPC),
    .result  (alu_result_s)
  );

  // Register file of the datapath; Clear overrides every load.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      pc_r  <= {WIDTH{1'b0}};
      ir_r  <= {WIDTH{1'b0}};
      mar_r <= {WIDTH{1'b0}};
      mdr_r <= {WIDTH{1'b0}};
      y_r   <= {WIDTH{1'b0}};
      zhi_r <= {WIDTH{1'b0}};
      zlo_r <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      r2_r  <= {WIDTH{1'b0}};
      r4_r  <= {WIDTH{1'b0}};
    end else begin
      if (PC_In)  pc_r  <= bus_s;
      if (IR_In)  ir_r  <= bus_s;
      if (MAR_In) mar_r <= bus_s;
      if (MDR_In) mdr_r <= Read ? MData_In : bus_s;
      if (Y_In)   y_r   <= bus_s;
      if (ZHI_IN) zhi_r <= alu_result_s[2*WIDTH-1:WIDTH];
      if (ZLO_In) zlo_r <= alu_result_s[WIDTH-1:0];
      if (HI_In)  hi_r  <= bus_s;
      if (LO_In)  lo_r  <= bus_s;
      if (R2_In)  r2_r  <= bus_s;
      if (R4_In)  r4_r  <= bus_s;
    end
  end

`ifdef DATAPATH_PROBE_EN
  assign BusMux_Out = bus_s;
  assign IR_Q       = ir_r;
  assign MAR_Q      = mar_r;
  assign HI_Q       = hi_r;
  assign LO_Q       = lo_r;
  assign PC_Q       = pc_r;
`endif

endmodule

// File: tb/tb_riscie_datapath.sv
// Self-checking bench for riscie_datapath: ALU vector table plus fetch,
// multiply, bus-priority and asynchronous-clear sequences.
module tb_riscie_datapath;
  import riscie_pkg::*;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] MData_In = 32'h0;
  logic [4:0]  CONTROL = 5'b0;
  logic IncPC = 1'b0, Read = 1'b0;
  logic PC_Out = 1'b0, MDR_Out = 1'b0, ZLO_Out = 1'b0, R2_Out = 1'b0, R4_Out = 1'b0;
  logic PC_In = 1'b0, MDR_In = 1'b0, MAR_In = 1'b0, IR_In = 1'b0, Y_In = 1'b0;
  logic ZHI_IN = 1'b0, ZLO_In = 1'b0, R2_In = 1'b0, R4_In = 1'b0, HI_In = 1'b0, LO_In = 1'b0;
`ifdef DATAPATH_PROBE_EN
  logic        ZHI_Out = 1'b0;
  logic [31:0] BusMux_Out, IR_Q, MAR_Q, HI_Q, LO_Q, PC_Q;
`endif

  riscie_datapath dut (
    .Clock(Clock), .Clear(Clear), .MData_In(MData_In), .CONTROL(CONTROL),
    .IncPC(IncPC), .Read(Read),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .R2_Out(R2_Out), .R4_Out(R4_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZHI_IN(ZHI_IN), .ZLO_In(ZLO_In), .R2_In(R2_In), .R4_In(R4_In),
    .HI_In(HI_In), .LO_In(LO_In)
`ifdef DATAPATH_PROBE_EN
    , .ZHI_Out(ZHI_Out), .BusMux_Out(BusMux_Out), .IR_Q(IR_Q), .MAR_Q(MAR_Q),
    .HI_Q(HI_Q), .LO_Q(LO_Q), .PC_Q(PC_Q)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[15];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_ctrl();
    CONTROL = 5'b0; IncPC = 1'b0; Read = 1'b0;
    PC_Out = 1'b0; MDR_Out = 1'b0; ZLO_Out = 1'b0; R2_Out = 1'b0; R4_Out = 1'b0;
    PC_In = 1'b0; MDR_In = 1'b0; MAR_In = 1'b0; IR_In = 1'b0; Y_In = 1'b0;
    ZHI_IN = 1'b0; ZLO_In = 1'b0; R2_In = 1'b0; R4_In = 1'b0; HI_In = 1'b0; LO_In = 1'b0;
  endtask

  // Advance one rising edge, then sample 1 time unit later and release strobes.
  task automatic tick();
    @(posedge Clock);
    #1;
    clr_ctrl();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    MData_In = v; Read = 1'b1; MDR_In = 1'b1;
    tick();
  endtask

  task automatic pop_z();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      check64(e.name, {dut.zhi_r, dut.zlo_r}, e.exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check64({tag, "_pc"},  {32'h0, dut.pc_r},  64'h0);
    check64({tag, "_ir"},  {32'h0, dut.ir_r},  64'h0);
    check64({tag, "_mar"}, {32'h0, dut.mar_r}, 64'h0);
    check64({tag, "_mdr"}, {32'h0, dut.mdr_r}, 64'h0);
    check64({tag, "_y"},   {32'h0, dut.y_r},   64'h0);
    check64({tag, "_z"},   {dut.zhi_r, dut.zlo_r}, 64'h0);
    check64({tag, "_hi"},  {32'h0, dut.hi_r},  64'h0);
    check64({tag, "_lo"},  {32'h0, dut.lo_r},  64'h0);
    check64({tag, "_r2"},  {32'h0, dut.r2_r},  64'h0);
    check64({tag, "_r4"},  {32'h0, dut.r4_r},  64'h0);
  endtask

  initial begin
    vecs[0]  = '{"add",      ALU_ADD, 32'd5,        32'd7,        64'd12};
    vecs[1]  = '{"add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'd2,        64'd1};
    vecs[2]  = '{"sub_neg",  ALU_SUB, 32'd3,        32'd5,        64'h00000000_FFFFFFFE};
    vecs[3]  = '{"mul_sgn",  ALU_MUL, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    vecs[4]  = '{"mul_big",  ALU_MUL, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    vecs[5]  = '{"and",      ALU_AND, 32'h0000F0F0, 32'h0000FF00, 64'h000000000000F000};
    vecs[6]  = '{"or",       ALU_OR,  32'h0000F0F0, 32'h00000F0F, 64'h000000000000FFFF};
    vecs[7]  = '{"shr31",    ALU_SHR, 32'h80000000, 32'd31,       64'd1};
    vecs[8]  = '{"shr_mask", ALU_SHR, 32'h000000F0, 32'h00000024, 64'h000000000000000F};
    vecs[9]  = '{"shl31",    ALU_SHL, 32'd1,        32'd31,       64'h0000000080000000};
    vecs[10] = '{"shl_mask", ALU_SHL, 32'd3,        32'h00000021, 64'd6};
    vecs[11] = '{"neg",      ALU_NEG, 32'd9,        32'd1,        64'h00000000_FFFFFFFF};
    vecs[12] = '{"not",      ALU_NOT, 32'd9,        32'h0F0F0F0F, 64'h00000000_F0F0F0F0};
    vecs[13] = '{"undef9",   5'b01001, 32'd9,       32'd9,        64'd0};
    vecs[14] = '{"undef31",  5'b11111, 32'd9,       32'd9,        64'd0};

    clr_ctrl();
    #1 Clear = 1'b1;
    #2;
    check_all_zero("reset");
    Clear = 1'b0;

    // Fetch from PC=0.
    PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; ZLO_In = 1'b1;
    tick();
    check64("t0_mar", {32'h0, dut.mar_r}, 64'd0);
    check64("t0_zlo", {32'h0, dut.zlo_r}, 64'd1);
    ZLO_Out = 1'b1; PC_In = 1'b1; Read = 1'b1; MDR_In = 1'b1; MData_In = 32'h70000000;
    tick();
    check64("t1_pc",  {32'h0, dut.pc_r},  64'd1);
    check64("t1_mdr", {32'h0, dut.mdr_r}, 64'h70000000);
    MDR_Out = 1'b1; IR_In = 1'b1;
    tick();
    check64("t2_ir", {32'h0, dut.ir_r}, 64'h70000000);

    load_mdr(32'd16);
    MDR_Out = 1'b1; R2_In = 1'b1;
    tick();
    check64("r2_load", {32'h0, dut.r2_r}, 64'd16);
    load_mdr(32'd32);
    MDR_Out = 1'b1; R4_In = 1'b1;
    tick();
    check64("r4_load", {32'h0, dut.r4_r}, 64'd32);

    // Multiply sequence T3..T5.
    R2_Out = 1'b1; Y_In = 1'b1;
    tick();
    R4_Out = 1'b1; CONTROL = ALU_MUL; ZHI_IN = 1'b1; ZLO_In = 1'b1;
    sb_q.push_back('{"mul_16x32", 64'd512});
    tick();
    pop_z();
    ZLO_Out = 1'b1; LO_In = 1'b1;
    tick();
    check64("lo_from_zlo", {32'h0, dut.lo_r}, 64'd512);
    R4_Out = 1'b1; HI_In = 1'b1;
    tick();
    check64("hi_from_bus", {32'h0, dut.hi_r}, 64'd32);

    // Bus priority, self-load and idle bus.
    PC_Out = 1'b1; R2_Out = 1'b1; R4_In = 1'b1;
    #1 check64("prio_pc_r2", {32'h0, dut.bus_s}, 64'd1);
    tick();
    check64("prio_r4_got_pc", {32'h0, dut.r4_r}, 64'd1);
    MDR_Out = 1'b1; ZLO_Out = 1'b1;
    #1 check64("prio_mdr_zlo", {32'h0, dut.bus_s}, 64'd32);
    clr_ctrl();
    ZLO_Out = 1'b1; R2_Out = 1'b1;
    #1 check64("prio_zlo_r2", {32'h0, dut.bus_s}, 64'd512);
    clr_ctrl();
    #1 check64("bus_idle", {32'h0, dut.bus_s}, 64'd0);
    R2_Out = 1'b1; R2_In = 1'b1;
    tick();
    check64("self_load_r2", {32'h0, dut.r2_r}, 64'd16);

    // ALU table through the real Y/bus path.
    for (int i = 0; i < 15; i++) begin
      load_mdr(vecs[i].a);
      MDR_Out = 1'b1; Y_In = 1'b1;
      tick();
      load_mdr(vecs[i].b);
      MDR_Out = 1'b1; CONTROL = vecs[i].op; ZHI_IN = 1'b1; ZLO_In = 1'b1;
      sb_q.push_back('{vecs[i].name, vecs[i].exp});
      tick();
      pop_z();
    end

    // Y loaded and consumed on the same edge: ALU sees the old Y.
    load_mdr(32'd5);
    MDR_Out = 1'b1; Y_In = 1'b1;
    tick();
    load_mdr(32'd7);
    MDR_Out = 1'b1; Y_In = 1'b1; CONTROL = ALU_ADD; ZHI_IN = 1'b1; ZLO_In = 1'b1;
    sb_q.push_back('{"y_old_value", 64'd12});
    tick();
    pop_z();
    check64("y_new_value", {32'h0, dut.y_r}, 64'd7);

    // ZHI and ZLO load independently.
    load_mdr(32'hFFFFFFFD);
    MDR_Out = 1'b1; Y_In = 1'b1;
    tick();
    load_mdr(32'd5);
    MDR_Out = 1'b1; CONTROL = ALU_MUL; ZLO_In = 1'b1;
    sb_q.push_back('{"zlo_only", 64'h00000000_FFFFFFF1});
    tick();
    pop_z();
    MDR_Out = 1'b1; CONTROL = ALU_MUL; ZHI_IN = 1'b1;
    sb_q.push_back('{"zhi_only", 64'hFFFFFFFF_FFFFFFF1});
    tick();
    pop_z();

    // IncPC wraps and overrides CONTROL.
    load_mdr(32'hFFFFFFFF);
    MDR_Out = 1'b1; IncPC = 1'b1; CONTROL = ALU_MUL; ZHI_IN = 1'b1; ZLO_In = 1'b1;
    sb_q.push_back('{"incpc_wrap", 64'd0});
    tick();
    pop_z();

    // Clear mid-cycle with loads active takes effect before the next edge.
    load_mdr(32'h12345678);
    MDR_Out = 1'b1; Y_In = 1'b1; R2_In = 1'b1; HI_In = 1'b1; IR_In = 1'b1;
    tick();
    MData_In = 32'hDEADBEEF; Read = 1'b1; MDR_In = 1'b1; PC_Out = 1'b1;
    R4_In = 1'b1; LO_In = 1'b1; ZLO_In = 1'b1; ZHI_IN = 1'b1; IncPC = 1'b1;
    #2 Clear = 1'b1;
    #1 check_all_zero("clear_mid");
    #1 Clear = 1'b0;
    clr_ctrl();
    @(posedge Clock);
    #1;

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
